booth_mult16_seq: RTL and testbench

//  Iterative radix-2 Booth signed multiplier, one Booth step per clock.

---
 rtl/booth_mult16_seq.sv | 98 +++++++++
 tb/tb_booth_mult16_seq.sv | 196 +++++++++++++++++++
 2 files changed

// File: rtl/booth_mult16_seq.sv
// Sequential radix-2 Booth signed multiplier: one Booth step per clock,
// start/done handshake, product held until the next accepted start.
module booth_mult16_seq #(
    parameter int WIDTH = 16
) (
    input  logic                 clk,
    input  logic                 clr,
    input  logic                 start,
    input  logic [WIDTH-1:0]     multiplicand,
    input  logic [WIDTH-1:0]     multiplier,
    output logic                 busy,
    output logic                 result_rdy,
    output logic [2*WIDTH-1:0]   product
);
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t               state_q, state_d;
    logic [WIDTH:0]       a_q, a_d;
    logic [WIDTH-1:0]     q_q, q_d;
    logic                 qm1_q, qm1_d;
    logic [WIDTH:0]       m_q, m_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [2*WIDTH-1:0]   prod_q, prod_d;
    logic [WIDTH:0]       a_sum;

    always_ff @(posedge clk) begin
        if (clr) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            q_q     <= '0;
            qm1_q   <= 1'b0;
            m_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            q_q     <= q_d;
            qm1_q   <= qm1_d;
            m_q     <= m_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        q_d     = q_q;
        qm1_d   = qm1_q;
        m_d     = m_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        a_sum   = a_q;

        unique case (state_q)
            S_IDLE: begin
                if (start) begin
                    a_d     = '0;
                    q_d     = multiplier;
                    qm1_d   = 1'b0;
                    m_d     = {multiplicand[WIDTH-1], multiplicand};
                    cnt_d   = '0;
                    state_d = S_RUN;
                end
            end
            S_RUN: begin
                unique case ({q_q[0], qm1_q})
                    2'b01:   a_sum = a_q + m_q;
                    2'b10:   a_sum = a_q - m_q;
                    default: a_sum = a_q;
                endcase
                // Arithmetic shift of {A,Q,q_m1}; A is one bit wider so -M never overflows
                a_d   = {a_sum[WIDTH], a_sum[WIDTH:1]};
                q_d   = {a_sum[0], q_q[WIDTH-1:1]};
                qm1_d = q_q[0];
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == CW'(WIDTH - 1)) begin
                    prod_d  = {a_d[WIDTH-1:0], q_d};
                    state_d = S_DONE;
                end
            end
            S_DONE: state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    assign busy       = (state_q != S_IDLE);
    assign result_rdy = (state_q == S_DONE);
    assign product    = prod_q;

endmodule

// File: tb/tb_booth_mult16_seq.sv
// Bench for booth_mult16_seq: cycle-level latency model plus $signed reference,
// directed corner cases and randomized multiplies.
module tb_booth_mult16_seq;
    logic        clk = 1'b0;
    logic        clr;
    logic        start;
    logic [15:0] mcand;
    logic [15:0] mplier;
    logic        busy;
    logic        result_rdy;
    logic [31:0] product;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    // Model state: cycles since acceptance (0 = idle), result when done
    int          m_cnt = 0;
    logic [31:0] m_prod = '0;
    logic [31:0] m_pend = '0;
    int          accepts = 0;
    int          completions = 0;
    int          rdy_pulses = 0;
    bit          cmp_en = 1'b0;

    booth_mult16_seq #(.WIDTH(16)) dut (
        .clk(clk), .clr(clr), .start(start),
        .multiplicand(mcand), .multiplier(mplier),
        .busy(busy), .result_rdy(result_rdy), .product(product)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Accept at edge E0; busy for 17 cycles, result_rdy during the 17th; product from then on.
    always @(posedge clk) begin
        cyc++;
        if (clr) begin
            m_cnt  = 0;
            m_prod = '0;
        end else if (m_cnt == 0) begin
            if (start) begin
                m_cnt  = 1;
                m_pend = int'($signed(mcand)) * int'($signed(mplier));
                accepts++;
            end
        end else if (m_cnt == 17) begin
            m_cnt = 0;
        end else begin
            m_cnt++;
            if (m_cnt == 17) begin
                m_prod = m_pend;
                completions++;
            end
        end
        cmp_en = 1'b1;
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("busy", 32'(busy), 32'(m_cnt != 0));
            chk("result_rdy", 32'(result_rdy), 32'(m_cnt == 17));
            chk("product", product, m_prod);
            if (result_rdy) rdy_pulses++;
        end
    end

    task automatic do_mult(input logic [15:0] a, input logic [15:0] b,
                           input logic [31:0] exp, input string name,
                           output int busy_n);
        bit got = 0;
        busy_n = 0;
        start = 1'b1; mcand = a; mplier = b;
        @(posedge clk); #1;
        start = 1'b0; mcand = 16'($urandom); mplier = 16'($urandom);
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (busy) busy_n++;
            if (result_rdy) begin
                got = 1;
                chk({name, "_lit"}, product, exp);
            end
            if (!busy) break;
        end
        chk({name, "_rdy_seen"}, 32'(got), 32'd1);
        @(posedge clk); #1;
    endtask

    function automatic logic [15:0] pick_op();
        case ($urandom_range(0, 7))
            0: return 16'h8000;
            1: return 16'h7FFF;
            2: return 16'h0000;
            3: return 16'hFFFF;
            4: return 16'h0001;
            default: return 16'($urandom);
        endcase
    endfunction

    initial begin
        int bn;
        int r1, r2, nr;
        bit got;
        clr = 1'b1; start = 1'b0; mcand = '0; mplier = '0;
        @(posedge clk); #1;
        start = 1'b1; mcand = 16'd9; mplier = 16'd9;   // clr must win over start
        @(posedge clk); #1;
        start = 1'b0;
        @(negedge clk);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_rdy", 32'(result_rdy), 32'd0);
        chk("reset_product", product, 32'd0);
        @(posedge clk); #1;
        clr = 1'b0;

        // 1: basic, busy length
        do_mult(16'd3, 16'd5, 32'h0000000F, "t1_3x5", bn);
        chk("t1_busy_cycles", 32'(bn), 32'd17);

        // 2: sign corners
        do_mult(16'h8000, 16'h8000, 32'h40000000, "t2_minmin", bn);
        do_mult(16'hFFFF, 16'h0001, 32'hFFFFFFFF, "t2_m1x1", bn);
        do_mult(16'h7FFF, 16'h8000, 32'hC0008000, "t2_maxmin", bn);

        // 3: start held high; next accept only from IDLE, 18 cycles apart
        start = 1'b1; mcand = 16'h7FFF; mplier = 16'h7FFF;
        r1 = -1; r2 = -1;
        for (int i = 0; i < 45; i++) begin
            @(negedge clk);
            if (result_rdy) begin
                chk("t3_lit", product, 32'h3FFF0001);
                if (r1 < 0) r1 = cyc; else if (r2 < 0) r2 = cyc;
            end
        end
        chk("t3_spacing", 32'(r2 - r1), 32'd18);
        @(posedge clk); #1;
        start = 1'b0;
        for (int i = 0; i < 20 && busy; i++) begin @(posedge clk); #1; end

        // 4: start during RUN is ignored
        start = 1'b1; mcand = 16'd4; mplier = 16'd6;
        @(posedge clk); #1;
        mcand = 16'd2; mplier = 16'd2;
        repeat (5) begin @(posedge clk); #1; end
        start = 1'b0;
        got = 0; nr = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (result_rdy) begin
                nr++;
                if (!got) chk("t4_lit", product, 32'h00000018);
                got = 1;
            end
        end
        chk("t4_one_rdy", 32'(nr), 32'd1);
        @(posedge clk); #1;

        // 5: clr at RUN edge 8
        start = 1'b1; mcand = 16'h1234; mplier = 16'h0010;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (7) @(posedge clk);
        #1 clr = 1'b1;
        @(posedge clk); #1;
        clr = 1'b0;
        @(negedge clk);
        chk("t5_busy", 32'(busy), 32'd0);
        chk("t5_rdy", 32'(result_rdy), 32'd0);
        chk("t5_product", product, 32'd0);
        @(posedge clk); #1;
        do_mult(16'd7, 16'hFFFD, 32'hFFFFFFEB, "t5_7xm3", bn);

        // 6: random stream
        for (int i = 0; i < 60000 && completions < 1012; i++) begin
            start  = ($urandom_range(0, 3) == 0);
            mcand  = pick_op();
            mplier = pick_op();
            @(posedge clk); #1;
        end
        start = 1'b0;
        repeat (20) @(posedge clk);
        @(negedge clk);
        chk("t6_enough", 32'(completions >= 1012), 32'd1);
        chk("t6_rdy_per_accept", 32'(rdy_pulses), 32'(completions));

        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
